// File: rtl/expr_pkg.sv
// expr_pkg: operator/ALU/error codes, FSM states and operator precedence for expr_engine.
package expr_pkg;
    localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_MUL = 3'd2, OP_DIV = 3'd3;
    localparam logic [2:0] OP_LP = 3'd4, OP_RP = 3'd5, OP_OK = 3'd6, OP_NEG = 3'd7;
    // RP never reaches the op stack, so unary POS reuses its code there
    localparam logic [2:0] OP_POS = OP_RP;
    localparam logic [1:0] AL_ADD = 2'd0, AL_SUB = 2'd1, AL_MUL = 2'd2, AL_DIV = 2'd3;
    localparam logic [2:0] E_NONE = 3'd0, E_SYNTAX = 3'd1, E_PAREN = 3'd2, E_DIV0 = 3'd3, E_OVF = 3'd4;
    typedef enum logic [2:0] {
        S_IDLE, S_FLUSH, S_COMPARE, S_EVAL, S_PUSH_OP, S_POP_LP, S_FINISH, S_ERROR
    } state_t;
    function automatic logic [1:0] prec(input logic [2:0] op);
        return (op == OP_NEG || op == OP_POS) ? 2'd3 :
               (op == OP_MUL || op == OP_DIV) ? 2'd2 :
               (op == OP_ADD || op == OP_SUB) ? 2'd1 : 2'd0;
    endfunction
endpackage

// File: rtl/expr_stack.sv
// expr_stack: synchronous LIFO with push, pop, replace-top / replace-top-two and clear.
module expr_stack #(
    parameter int W = 16,
    parameter int DEPTH = 8
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic                       clr,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       rep,
    input  logic                       two,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               top,
    output logic [W-1:0]               second,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] ONE = CW'(1);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] i_top, i_sec;
    assign i_top = AW'(count - ONE);
    assign i_sec = AW'(count - ONE - ONE);
    assign top = mem[i_top];
    assign second = mem[i_sec];
    assign empty = count == '0;
    assign full = count == CW'(DEPTH);
    always_ff @(posedge Clock or negedge Reset)
        if (!Reset) count <= '0;
        else if (clr) count <= '0;
        else if (push && !full) count <= count + ONE;
        else if ((pop && !empty) || (rep && two)) count <= count - ONE;
    always_ff @(posedge Clock)
        if (!clr && push && !full) mem[AW'(count)] <= din;
        else if (!clr && rep) mem[two ? i_sec : i_top] <= din;
endmodule

// File: rtl/expr_engine.sv
// expr_engine: shunting-yard expression evaluator with internal stacks and an external req/ack ALU.
// Defining EXPR_UNARY_EN enables unary +/- (POS/NEG) on a leading ADD/SUB token.
module expr_engine import expr_pkg::*; #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             clr,
    input  logic             tok_valid,
    output logic             tok_ready,
    input  logic             tok_is_num,
    input  logic [2:0]       tok_op,
    input  logic [WIDTH-1:0] tok_num,
    output logic             al_req,
    output logic [1:0]       al_op,
    output logic [WIDTH-1:0] al_a,
    output logic [WIDTH-1:0] al_b,
    input  logic             al_ack,
    input  logic [WIDTH-1:0] al_res,
    input  logic             al_err,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_data,
    output logic [2:0]       res_err
);
    localparam int CW = $clog2(DEPTH + 1);
    state_t state, nstate;
    logic [2:0] cur_op, ncur, err_q, nerr;
    logic expect_num, nexp, acc, clr_stk, unary_t, pos_t, need_ok, fin, one;
    logic d_push, d_rep, d_two, d_empty, d_full, o_push, o_pop, o_empty, o_full;
    logic [WIDTH-1:0] d_top, d_sec;
    logic [2:0] o_top, o_sec;
    logic [CW-1:0] d_cnt, o_cnt;
    logic unused_ok;
    assign unused_ok = ^{o_sec, o_cnt, d_empty};
    expr_stack #(.W(WIDTH), .DEPTH(DEPTH)) u_data (
        .Clock(Clock), .Reset(Reset), .clr(clr_stk), .push(d_push), .pop(1'b0),
        .rep(d_rep), .two(d_two), .din(d_rep ? al_res : tok_num),
        .top(d_top), .second(d_sec), .empty(d_empty), .full(d_full), .count(d_cnt)
    );
    expr_stack #(.W(3), .DEPTH(DEPTH)) u_op (
        .Clock(Clock), .Reset(Reset), .clr(clr_stk), .push(o_push), .pop(o_pop),
        .rep(1'b0), .two(1'b0), .din(cur_op),
        .top(o_top), .second(o_sec), .empty(o_empty), .full(o_full), .count(o_cnt)
    );
`ifdef EXPR_UNARY_EN
    assign unary_t = o_top == OP_NEG || o_top == OP_POS;
    assign pos_t = o_top == OP_POS;
`else
    assign unary_t = 1'b0;
    assign pos_t = 1'b0;
`endif
    assign need_ok = d_cnt >= (unary_t ? CW'(1) : CW'(2));
    assign tok_ready = state == S_IDLE && !clr;
    assign acc = tok_valid && tok_ready;
    assign al_req = state == S_EVAL && need_ok && !pos_t;
    // binary operator codes coincide with the ALU op codes
    assign al_op = unary_t ? AL_SUB : o_top[1:0];
    assign al_a = unary_t ? '0 : d_sec;
    assign al_b = d_top;
    assign fin = state == S_FINISH;
    assign one = d_cnt == CW'(1);
    always_comb begin
        nstate = state;
        ncur = cur_op;
        nerr = err_q;
        nexp = expect_num;
        d_push = 1'b0;
        d_rep = 1'b0;
        d_two = 1'b0;
        o_push = 1'b0;
        o_pop = 1'b0;
        clr_stk = 1'b0;
        case (state)
            S_IDLE: if (acc) begin
                if (tok_is_num) begin
                    if (!expect_num) begin nstate = S_ERROR; nerr = E_SYNTAX; end
                    else if (d_full) begin nstate = S_ERROR; nerr = E_OVF; end
                    else begin d_push = 1'b1; nexp = 1'b0; end
                end else if (tok_op == OP_LP) begin
                    if (expect_num) begin ncur = OP_LP; nstate = S_PUSH_OP; end
                    else begin nstate = S_ERROR; nerr = E_SYNTAX; end
                end
`ifdef EXPR_UNARY_EN
                else if (expect_num && (tok_op == OP_ADD || tok_op == OP_SUB)) begin
                    ncur = tok_op == OP_SUB ? OP_NEG : OP_POS;
                    nstate = S_PUSH_OP;
                end
`endif
                else if (expect_num || tok_op > OP_OK) begin nstate = S_ERROR; nerr = E_SYNTAX; end
                else begin ncur = tok_op; nstate = S_FLUSH; nexp = tok_op != OP_RP; end
            end
            S_FLUSH:
                if (!o_empty) nstate = S_COMPARE;
                else if (cur_op == OP_RP) begin nstate = S_ERROR; nerr = E_PAREN; end
                else nstate = cur_op == OP_OK ? S_FINISH : S_PUSH_OP;
            S_COMPARE:
                if (o_top == OP_LP) begin
                    if (cur_op == OP_OK) begin nstate = S_ERROR; nerr = E_PAREN; end
                    else nstate = cur_op == OP_RP ? S_POP_LP : S_PUSH_OP;
                end else
                    nstate = (cur_op == OP_RP || cur_op == OP_OK || prec(o_top) >= prec(cur_op)) ? S_EVAL : S_PUSH_OP;
            S_EVAL:
                if (!need_ok) begin nstate = S_ERROR; nerr = E_SYNTAX; end
                else if (pos_t) begin o_pop = 1'b1; nstate = S_FLUSH; end
                else if (al_ack && al_err) begin nstate = S_ERROR; nerr = E_DIV0; end
                else if (al_ack) begin o_pop = 1'b1; d_rep = 1'b1; d_two = !unary_t; nstate = S_FLUSH; end
            S_PUSH_OP:
                if (o_full) begin nstate = S_ERROR; nerr = E_OVF; end
                else begin o_push = 1'b1; nstate = S_IDLE; end
            S_POP_LP: begin o_pop = 1'b1; nstate = S_IDLE; end
            S_FINISH, S_ERROR: begin clr_stk = 1'b1; nexp = 1'b1; nstate = S_IDLE; end
        endcase
        if (clr) begin
            nstate = S_IDLE;
            nexp = 1'b1;
            clr_stk = 1'b1;
        end
    end
    always_ff @(posedge Clock or negedge Reset)
        if (!Reset) begin
            state <= S_IDLE;
            cur_op <= OP_ADD;
            err_q <= E_NONE;
            expect_num <= 1'b1;
            res_valid <= 1'b0;
            res_data <= '0;
            res_err <= E_NONE;
        end else begin
            state <= nstate;
            cur_op <= ncur;
            err_q <= nerr;
            expect_num <= nexp;
            res_valid <= !clr && (fin || state == S_ERROR);
            res_data <= (!clr && fin && one) ? d_top : '0;
            res_err <= clr ? E_NONE : state == S_ERROR ? err_q : (fin && !one) ? E_SYNTAX : E_NONE;
        end
endmodule

// File: tb/tb_expr_engine.sv
// tb_expr_engine: directed token sequences against a scoreboard of expected results, with a variable-latency ALU model.
module tb_expr_engine;
    import expr_pkg::*;
    localparam int W = 16;
    logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0;
    logic tok_valid = 1'b0, tok_is_num = 1'b0, al_ack = 1'b0, al_err = 1'b0;
    logic [2:0] tok_op = 3'd0;
    logic [W-1:0] tok_num = '0, al_res = '0;
    logic tok_ready, al_req, res_valid;
    logic [1:0] al_op, h_op;
    logic [W-1:0] al_a, al_b, res_data, h_a, h_b;
    logic [2:0] res_err;
    logic [W+2:0] exp_q[$];
    logic [W+2:0] e;
    int checks = 0, fails = 0, lat = 1, acnt = 0, last_run = 0, unstable = 0;
    string name = "reset";
    always #5 clk = ~clk;
    expr_engine #(.WIDTH(W), .DEPTH(4)) dut (
        .Clock(clk), .Reset(rst_n), .clr(clr),
        .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_is_num(tok_is_num),
        .tok_op(tok_op), .tok_num(tok_num),
        .al_req(al_req), .al_op(al_op), .al_a(al_a), .al_b(al_b),
        .al_ack(al_ack), .al_res(al_res), .al_err(al_err),
        .res_valid(res_valid), .res_data(res_data), .res_err(res_err)
    );
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s [%s]: got %0h, expected %0h", tag, name, obs, expv);
        end
    endtask
    // ALU model: acks after lat cycles of al_req, drops abandoned requests
    always @(negedge clk) begin
        al_ack = 1'b0;
        al_err = 1'b0;
        if (!al_req) acnt = 0;
        else begin
            if (acnt == 0) begin h_op = al_op; h_a = al_a; h_b = al_b; end
            else if ({al_op, al_a, al_b} !== {h_op, h_a, h_b}) unstable++;
            acnt++;
            if (acnt == lat) begin
                al_ack = 1'b1;
                last_run = acnt;
                acnt = 0;
                case (al_op)
                    2'd0: al_res = al_a + al_b;
                    2'd1: al_res = al_a - al_b;
                    2'd2: al_res = W'(al_a * al_b);
                    default: al_res = al_b == '0 ? '0 : W'($signed(al_a) / $signed(al_b));
                endcase
                al_err = al_op == 2'd3 && al_b == '0;
            end
        end
    end
    always @(negedge clk) if (res_valid) begin
        if (exp_q.size() == 0) check("spurious res_valid", 32'(exp_q.size()), 1);
        else begin
            e = exp_q.pop_front();
            check("res_err", 32'(res_err), 32'(e[W+2:W]));
            check("res_data", 32'(res_data), 32'(e[W-1:0]));
        end
    end
    task automatic send(input logic isnum, input logic [2:0] op, input logic [W-1:0] v, output int n);
        n = 0;
        @(negedge clk);
        while (!tok_ready && n < 100) begin @(negedge clk); n++; end
        check("tok_ready", 32'(tok_ready), 1);
        tok_valid = 1'b1; tok_is_num = isnum; tok_op = op; tok_num = v;
        @(posedge clk);
        #1 tok_valid = 1'b0;
    endtask
    task automatic num(input logic [W-1:0] v);
        int n;
        send(1'b1, 3'd0, v, n);
    endtask
    task automatic op(input logic [2:0] o);
        int n;
        send(1'b0, o, '0, n);
    endtask
    task automatic expect_res(input logic [2:0] err, input logic [W-1:0] d);
        exp_q.push_back({err, d});
    endtask
    task automatic wait_done();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin @(negedge clk); n++; end
        check("result timeout", 32'(exp_q.size()), 0);
    endtask
    initial begin
        int n;
        @(negedge clk);
        check("reset tok_ready", 32'(tok_ready), 1);
        check("reset al_req", 32'(al_req), 0);
        check("reset res_valid", 32'(res_valid), 0);
        check("reset res_data", 32'(res_data), 0);
        check("reset res_err", 32'(res_err), 0);
        rst_n = 1'b1;
        name = "2+3*4"; lat = 1;
        num(16'd2); op(OP_ADD); num(16'd3);
        send(1'b0, OP_MUL, '0, n);
        check("number turnaround", 32'(n), 0);
        send(1'b1, 3'd0, 16'd4, n);
        check("operator turnaround", 32'(n), 3);
        expect_res(3'd0, 16'd14); op(OP_OK); wait_done();
        name = "(2+3)*4"; lat = 5;
        op(OP_LP); num(16'd2); op(OP_ADD); num(16'd3); op(OP_RP); op(OP_MUL); num(16'd4);
        expect_res(3'd0, 16'd20); op(OP_OK); wait_done();
        check("al_req hold cycles", 32'(last_run), 5);
        check("operand stability", 32'(unstable), 0);
        name = "8/0"; lat = 2;
        num(16'd8); op(OP_DIV); num(16'd0);
        expect_res(3'd3, 16'd0); op(OP_OK); wait_done();
        name = "1 after div0";
        num(16'd1); expect_res(3'd0, 16'd1); op(OP_OK); wait_done();
        name = "2+3)";
        num(16'd2); op(OP_ADD); num(16'd3); expect_res(3'd2, 16'd0); op(OP_RP); wait_done();
        name = "(1=";
        op(OP_LP); num(16'd1); expect_res(3'd2, 16'd0); op(OP_OK); wait_done();
        name = "1 2";
        num(16'd1); expect_res(3'd1, 16'd0); num(16'd2); wait_done();
        name = "5xLP";
        repeat (4) op(OP_LP);
        expect_res(3'd4, 16'd0); op(OP_LP); wait_done();
        name = "clr in IDLE";
        @(negedge clk);
        clr = 1'b1; tok_valid = 1'b1; tok_is_num = 1'b1; tok_num = 16'd9;
        #1 check("tok_ready under clr", 32'(tok_ready), 0);
        @(posedge clk);
        #1 clr = 1'b0; tok_valid = 1'b0;
        name = "clr mid-EVAL"; lat = 20;
        num(16'd2); op(OP_ADD); num(16'd3); op(OP_OK);
        n = 0;
        while (!al_req && n < 50) begin @(negedge clk); n++; end
        check("al_req raised", 32'(al_req), 1);
        clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        @(negedge clk);
        check("al_req dropped", 32'(al_req), 0);
        repeat (10) @(negedge clk);
        name = "1+1 after clr"; lat = 1;
        num(16'd1); op(OP_ADD); num(16'd1); expect_res(3'd0, 16'd2); op(OP_OK); wait_done();
        name = "-5+2";
`ifdef EXPR_UNARY_EN
        op(OP_SUB); num(16'd5); op(OP_ADD); num(16'd2);
        expect_res(3'd0, 16'hFFFD); op(OP_OK); wait_done();
`else
        expect_res(3'd1, 16'd0); op(OP_SUB); wait_done();
`endif
        name = "end";
        repeat (3) @(negedge clk);
        check("scoreboard drained", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", checks, fails);
        $finish;
    end
endmodule
